// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and the fetch FSM encoding.
// Imported by fetch_stage, if_id_reg and decode_stage.
package fetch_stage_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'h0,
    OPC_SUB  = 4'h1,
    OPC_AND  = 4'h2,
    OPC_OR   = 4'h3,
    OPC_LDI  = 4'h4,
    OPC_LD   = 4'h5,
    OPC_ST   = 4'h6,
    OPC_BEQ  = 4'h7,
    OPC_JMP  = 4'h8,
    OPC_HALT = 4'hF
  } opcode_t;

  localparam logic [3:0] CPU_HALT_OPC = 4'(OPC_HALT);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT_ID = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_t;

  function automatic pc_t pc_inc(input pc_t pc);
    return pc + pc_t'(2);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load beats clear, clear drops only the valid bit, otherwise hold.
// Zero latency beyond the register itself; holding is what stalls decode's view.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  instr_t load_instr,
  input  pc_t    load_pc_plus2,
  output logic   id_valid,
  output instr_t id_instr,
  output pc_t    id_pc_plus2
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc_plus2 <= '0;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_instr    <= load_instr;
      id_pc_plus2 <= load_pc_plus2;
    end else if (clear) begin
      id_valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM and the IF/ID register.
// A word lands in id_* the edge after imem_rdy; a decode stall parks the FSM in WAIT_ID with no request.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter pc_t        RESET_PC = 16'h0000,
  parameter logic [3:0] HALT_OPC = CPU_HALT_OPC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_plus2,
  output logic        halted
);

  fetch_state_t state;
  pc_t          pc;
  pc_t          pc_next;
  logic         halt_pend;
  logic         handshake;
  logic         blocked;
  logic         take;
  logic         is_halt;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign pc_next   = pc_inc(pc);

  assign handshake = id_valid & id_ready;
  assign blocked   = id_valid & ~id_ready;
  // A response arriving while the old word is still stuck in IF/ID is dropped and refetched later.
  assign take      = imem_req & imem_rdy & ~redirect & ~blocked;
  assign is_halt   = (imem_data[15:12] == HALT_OPC);

  if_id_reg u_if_id (
    .clk           (clk),
    .rst           (rst),
    .load          (take),
    .clear         (redirect | handshake),
    .load_instr    (imem_data),
    .load_pc_plus2 (pc_next),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc_plus2   (id_pc_plus2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      halt_pend <= 1'b0;
      halted    <= 1'b0;
    end else if (redirect) begin
      pc        <= redirect_pc;
      halt_pend <= 1'b0;
      halted    <= 1'b0;
      // An owed response that shows up in this same cycle is already drained.
      if (state == ST_FETCH || state == ST_DRAIN)
        state <= imem_rdy ? ST_FETCH : ST_DRAIN;
      else
        state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_rdy) begin
            if (blocked) begin
              state <= ST_WAIT_ID;
            end else begin
              pc <= pc_next;
              if (is_halt) begin
                halt_pend <= 1'b1;
                state     <= ST_WAIT_ID;
              end else if (!id_ready) begin
                state <= ST_WAIT_ID;
              end
            end
          end
        end
        ST_WAIT_ID: begin
          if (!blocked) begin
            state     <= halt_pend ? ST_HALT : ST_FETCH;
            halted    <= halt_pend;
            halt_pend <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (imem_rdy)
            state <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory, directed scenarios, then randomized traffic vs a model.
module tb_fetch_stage;

  localparam logic [3:0] HALT = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus2;
  logic        halted;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc_plus2 (id_pc_plus2),
    .halted      (halted)
  );

  int nchk = 0;
  int nerr = 0;

  // Instruction memory contents: a hash of the address unless overridden.
  logic [15:0] mem_ovr [logic [15:0]];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    w = (a * 16'h3B1D) ^ 16'hA5C3;
    if (w[15:12] == HALT && w[3:0] != 4'h0) w[15:12] = 4'h7;
    return w;
  endfunction

  // Memory: one request at a time, answered after a per-request latency.
  bit          mbusy;
  int          mrem;
  logic [15:0] maddr;
  int          fixed_lat;

  // Stimulus controls for the next cycle.
  bit          c_redirect;
  logic [15:0] c_rpc;
  bit          c_ready;

  // Behavioural model: architectural PC, IF/ID slot and fetch-activity flags.
  logic [15:0] m_pc, m_instr, m_pc2;
  bit          m_v;
  bit          m_stale;  // a response is owed for a cancelled request
  bit          m_wait;   // no request: waiting for decode to take the held word
  bit          m_halt;
  bit          m_hpend;  // the held word is a halt

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
    m_v = 0; m_stale = 0; m_wait = 0; m_halt = 0; m_hpend = 0;
  endtask

  // One clock: entered and left at a negedge with settled DUT outputs.
  task automatic cycle();
    bit req_e, hs, blocked, ld;
    if (!mbusy && imem_req) begin
      mbusy = 1;
      maddr = imem_addr;
      mrem  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
    imem_rdy    = mbusy && (mrem == 1);
    imem_data   = imem_rdy ? mem_word(maddr) : 16'($urandom);
    redirect    = c_redirect;
    redirect_pc = c_rpc;
    id_ready    = c_ready;

    req_e = !m_stale && !m_wait && !m_halt;
    chk("imem_req", 16'(imem_req), 16'(req_e));
    if (req_e) chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", 16'(id_valid), 16'(m_v));
    if (m_v) begin
      chk("id_instr", id_instr, m_instr);
      chk("id_pc_plus2", id_pc_plus2, m_pc2);
    end
    chk("halted", 16'(halted), 16'(m_halt));

    hs = m_v && c_ready;
    blocked = m_v && !c_ready;
    ld = 0;
    if (c_redirect) begin
      m_stale = (req_e || m_stale) && !imem_rdy;
      m_pc = c_rpc; m_v = 0; m_wait = 0; m_halt = 0; m_hpend = 0;
    end else if (req_e) begin
      if (imem_rdy && blocked) begin
        m_wait = 1;
      end else if (imem_rdy) begin
        ld = 1;
        m_instr = imem_data;
        m_pc2 = m_pc + 16'd2;
        m_pc = m_pc2;
        m_v = 1;
        m_hpend = (imem_data[15:12] == HALT);
        m_wait = m_hpend || !c_ready;
      end
    end else if (m_stale) begin
      if (imem_rdy) m_stale = 0;
    end else if (m_wait) begin
      if (!blocked) begin
        m_wait = 0;
        m_halt = m_hpend;
        m_hpend = 0;
      end
    end
    if (hs && !ld && !c_redirect) m_v = 0;

    @(posedge clk);
    if (imem_rdy) mbusy = 0;
    else if (mbusy) mrem--;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_rdy = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_id_valid", 16'(id_valid), 16'h0000);
    chk("rst_id_instr", id_instr, 16'h0000);
    chk("rst_id_pc_plus2", id_pc_plus2, 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    mbusy = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_rdy = 0; imem_data = 0; redirect = 0; redirect_pc = 0; id_ready = 0;
    mbusy = 0; mrem = 0; maddr = 0;
    fixed_lat = 1; c_ready = 1; c_redirect = 0; c_rpc = 16'h0000;
    model_reset();
    @(negedge clk);
    do_reset();

    // Back-to-back fetch from a 1-cycle memory.
    chk("first_req", 16'(imem_req), 16'h0001);
    cycle(); chk("seq_pc2_0", id_pc_plus2, 16'h0002);
    cycle(); chk("seq_pc2_1", id_pc_plus2, 16'h0004);
    cycle(); chk("seq_pc2_2", id_pc_plus2, 16'h0006);

    // Decode stall holding 1234.
    mem_ovr[16'h0100] = 16'h1234;
    c_redirect = 1; c_rpc = 16'h0100; cycle();
    c_redirect = 0; c_ready = 0; cycle();
    repeat (3) begin
      chk("stall_req", 16'(imem_req), 16'h0000);
      chk("stall_instr", id_instr, 16'h1234);
      cycle();
    end
    c_ready = 1; cycle();
    chk("resume_req", 16'(imem_req), 16'h0001);
    chk("resume_addr", imem_addr, 16'h0102);

    // Redirect while a 3-cycle request is outstanding.
    fixed_lat = 3; cycle();
    c_redirect = 1; c_rpc = 16'h0040; cycle();
    c_redirect = 0;
    for (int i = 0; i < 20 && !id_valid; i++) cycle();
    chk("redir_valid", 16'(id_valid), 16'h0001);
    chk("redir_pc2", id_pc_plus2, 16'h0042);
    chk("redir_instr", id_instr, mem_word(16'h0040));

    // Halt word at 0x0010, then restart by redirect.
    fixed_lat = 1; mem_ovr[16'h0010] = 16'hF000; c_ready = 0;
    c_redirect = 1; c_rpc = 16'h0010;
    for (int i = 0; i < 10 && mbusy; i++) cycle();
    cycle();
    c_redirect = 0; cycle();
    chk("halt_instr", id_instr, 16'hF000);
    chk("halt_deliver", 16'(id_valid), 16'h0001);
    chk("halt_noreq", 16'(imem_req), 16'h0000);
    c_ready = 1; cycle();
    repeat (4) begin
      chk("halted_flag", 16'(halted), 16'h0001);
      chk("halted_noreq", 16'(imem_req), 16'h0000);
      cycle();
    end
    c_redirect = 1; c_rpc = 16'h0020; cycle();
    c_redirect = 0;
    chk("unhalt_flag", 16'(halted), 16'h0000);
    chk("unhalt_req", 16'(imem_req), 16'h0001);
    chk("unhalt_addr", imem_addr, 16'h0020);

    // PC wrap.
    c_redirect = 1; c_rpc = 16'hFFFE; cycle();
    c_redirect = 0;
    chk("wrap_pre", imem_addr, 16'hFFFE);
    cycle();
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_pc2", id_pc_plus2, 16'h0000);

    // Reset in the middle of a request at 0x0008.
    fixed_lat = 3;
    c_redirect = 1; c_rpc = 16'h0008; cycle();
    c_redirect = 0;
    for (int i = 0; i < 10 && !imem_req; i++) cycle();
    cycle();
    chk("mid_req", 16'(imem_req), 16'h0001);
    chk("mid_addr", imem_addr, 16'h0008);
    do_reset();
    chk("post_rst_req", 16'(imem_req), 16'h0001);
    chk("post_rst_addr", imem_addr, 16'h0000);

    // Randomized traffic against the model.
    fixed_lat = 0;
    repeat (3000) begin
      c_ready    = ($urandom_range(0, 3) != 0);
      c_redirect = ($urandom_range(0, 19) == 0);
      c_rpc      = 16'($urandom) & 16'hFFFE;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
